// File: rtl/comb_bist_pkg.sv
// comb_bist_pkg: shared types and constants for the
// combinational-block BIST controller.
package comb_bist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_CAPTURE,
        S_DONE
    } state_t;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] d;
    } opnd_t;

    // Fibonacci taps 16,14,13,11 map to bits 0,2,3,5
    localparam logic [15:0] LFSR_TAPS     = 16'h002D;
    localparam logic [15:0] MISR_POLY     = 16'h002D;
    localparam logic [15:0] OPND_XOR      = 16'h5A5A;
    localparam logic [15:0] ZERO_SEED_SUB = 16'h0001;

    function automatic logic [15:0] seed_fix(input logic [15:0] s);
        return (s == 16'h0) ? ZERO_SEED_SUB : s;
    endfunction

    function automatic opnd_t make_opnd(input logic [15:0] l);
        opnd_t o;
        o.a = l;
        o.b = {l[7:0], l[15:8]};
        o.c = ~l;
        o.d = l ^ OPND_XOR;
        return o;
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// lfsr16_step: one combinational step of a 16-bit LFSR,
// Fibonacci (shift right) or Galois/MISR (shift left).
module lfsr16_step
    import comb_bist_pkg::*;
#(
    parameter logic [15:0] POLY   = LFSR_TAPS,
    parameter bit          GALOIS = 1'b0
) (
    input  logic [15:0] cur,
    input  logic        serial_in,
    output logic [15:0] nxt
);

    // Next state; serial_in folds into the feedback bit
    always_comb begin
        nxt = '0;
        if (GALOIS) begin
            nxt = {cur[14:0], 1'b0}
                ^ (cur[15] ? POLY : 16'h0)
                ^ {15'b0, serial_in};
        end else begin
            nxt = {(^(cur & POLY)) ^ serial_in, cur[15:1]};
        end
    end

endmodule

// File: rtl/comb_bist_controller.sv
// comb_bist_controller: drives LFSR operand vectors into the
// logic block and compacts its response into a MISR signature.
module comb_bist_controller
    import comb_bist_pkg::*;
#(
    parameter int          NUM_PATTERNS  = 256,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] SEED          = 16'hACE1,
    parameter int          CNT_W         = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [15:0]      expected_sig,
    input  logic             out_signal,
    output logic [15:0]      A,
    output logic [15:0]      B,
    output logic [15:0]      C,
    output logic [15:0]      D,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      signature,
    output logic [CNT_W-1:0] pattern_count
);

    localparam logic [15:0] SEED_EFF = seed_fix(SEED);
    localparam int SET_W =
        (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SET_LAST =
        SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        CNT_W'(NUM_PATTERNS - 1);

    state_t           state;
    opnd_t            ops;
    logic [15:0]      lfsr;
    logic [15:0]      lfsr_nxt;
    logic [15:0]      sig_nxt;
    logic [SET_W-1:0] settle_cnt;

    lfsr16_step #(
        .POLY   (LFSR_TAPS),
        .GALOIS (1'b0)
    ) u_pat_step (
        .cur       (lfsr),
        .serial_in (1'b0),
        .nxt       (lfsr_nxt)
    );

    lfsr16_step #(
        .POLY   (MISR_POLY),
        .GALOIS (1'b1)
    ) u_misr_step (
        .cur       (signature),
        .serial_in (out_signal),
        .nxt       (sig_nxt)
    );

    assign A = ops.a;
    assign B = ops.b;
    assign C = ops.c;
    assign D = ops.d;

    // Run sequencing with all outputs registered
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            lfsr          <= SEED_EFF;
            ops           <= '0;
            signature     <= '0;
            pattern_count <= '0;
            settle_cnt    <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
        end else if (abort && busy) begin
            state <= S_IDLE;
            ops   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            pass  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start && !abort) begin
                        state         <= S_APPLY;
                        lfsr          <= SEED_EFF;
                        ops           <= make_opnd(SEED_EFF);
                        signature     <= '0;
                        pattern_count <= '0;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                    end
                end
                S_APPLY: begin
                    settle_cnt <= '0;
                    state      <= (SETTLE_CYCLES > 0) ?
                                  S_SETTLE : S_CAPTURE;
                end
                S_SETTLE: begin
                    if (settle_cnt == SET_LAST) begin
                        state <= S_CAPTURE;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    signature     <= sig_nxt;
                    lfsr          <= lfsr_nxt;
                    pattern_count <= pattern_count + 1'b1;
                    if (pattern_count == CNT_LAST) begin
                        state <= S_DONE;
                        ops   <= '0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        pass  <= (sig_nxt == expected_sig);
                    end else begin
                        state <= S_APPLY;
                        ops   <= make_opnd(lfsr_nxt);
                    end
                end
                default: begin
                    state <= S_IDLE;
                    ops   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/comb_bist_controller.md
# comb_bist_controller

Self-test driver for the 16-bit four-operand combinational logic block. It sources pseudo-random A/B/C/D operand vectors from an LFSR and holds each vector for a settle window. It then samples the block's single-bit `out_signal` response and compacts the responses into a 16-bit MISR signature, which it compares against an expected value. It sits on the opposite side of the logic block's interface: it drives that block's inputs and consumes its output.

## Interface
- `NUM_PATTERNS`, 256: vectors per run, legal range 1..2^CNT_W−1.
- `SETTLE_CYCLES`, 1: hold cycles between apply and capture, 0 legal.
- `SEED`, 16'hACE1: initial pattern LFSR state; 0 is replaced by 16'h0001.
- `CNT_W`, 16: pattern counter width.

Ports:
- `clk` in 1: single clock, all state on rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: begin a run; sampled in IDLE or DONE only.
- `abort` in 1: terminate the run; highest priority after reset.
- `expected_sig` in 16: golden signature, sampled in the final CAPTURE cycle.
- `out_signal` in 1: response from the logic block.
- `A`, `B`, `C`, `D` out 16 each: operand vectors.
- `busy` out 1: run in progress.
- `done` out 1: run completed; level signal.
- `pass` out 1: signature matched; valid when `done`=1.
- `signature` out 16: current MISR value.
- `pattern_count` out CNT_W: number of patterns captured.

## Operation
- States: IDLE, APPLY, SETTLE, CAPTURE, DONE.
- IDLE/DONE + `start`: load lfsr←SEED (or 1 if SEED=0), sig←0, count←0 → APPLY. Clear `done` and `pass`.
- APPLY: one cycle → SETTLE if SETTLE_CYCLES>0, else CAPTURE.
- SETTLE: counts SETTLE_CYCLES cycles → CAPTURE.
- CAPTURE: sig←MISR(sig, `out_signal`); lfsr advances; count+1. Then, if count (pre-increment) = NUM_PATTERNS−1, go to DONE and set pass←(sig_next==`expected_sig`); otherwise go to APPLY.
- Pattern LFSR: Fibonacci, taps 16,14,13,11. fb = l[0]^l[2]^l[3]^l[5]; l←{fb, l[15:1]}. ACE1 → 5670.
- Vector derivation, from the current lfsr register:
  - A = l
  - B = {l[7:0], l[15:8]}
  - C = ~l
  - D = l ^ 16'h5A5A
- A..D are forced to 0 in IDLE and DONE.
- MISR: sig_next = {sig[14:0],1'b0} ^ (sig[15] ? 16'h002D : 0) ^ {15'b0, out_signal}.
- `abort` in any busy state → IDLE next cycle. `done`=0, `pass`=0; `signature` and `pattern_count` hold their last values.
- `start` while busy is ignored. `start` and `abort` together in IDLE: abort wins and the block stays in IDLE.
- `busy` = state ∈ {APPLY, SETTLE, CAPTURE}.

## Timing
- Reset values (all outputs): 0. State IDLE, lfsr=SEED.
- Cycles per pattern: 2+SETTLE_CYCLES.
- `start` sampled at edge t → APPLY in cycle t+1. `done` rises in cycle t+1+NUM_PATTERNS·(2+SETTLE_CYCLES).
- A..D change only on the APPLY entry edge and stay stable through CAPTURE. `out_signal` is sampled at the end of the CAPTURE cycle.
- `pattern_count` and `signature` update on the CAPTURE edge and are registered outputs.
- `done` and `pass` are registered and held until the next accepted `start` or reset.
- `rst_n` low mid-run forces all state to reset values on that edge.

## Structure
- Package `comb_bist_pkg`:
  - state enum
  - LFSR tap mask
  - MISR polynomial 16'h002D
  - operand XOR constant 16'h5A5A
  - zero-seed substitute value
- Sub-module `lfsr16_step`: combinational next-state function with a parameterised polynomial and a serial input. Instantiated twice: pattern LFSR with serial-in tied 0, and MISR.
- Top level holds the FSM, the settle counter and the pattern counter.

## Test plan
- Reset then idle: all outputs 0, A..D=0, `busy`=0 for 10 cycles.
- NUM_PATTERNS=3, SETTLE_CYCLES=1, `out_signal` tied 1, `expected_sig`=16'h0007, `start` at t:
  - A=ACE1 during the first APPLY, then 5670.
  - `done`=1 and `pass`=1 at t+10.
  - `signature`=0007, `pattern_count`=3.
- Same setup with `out_signal` tied 0 and `expected_sig`=16'h0001: `signature`=0000, `pass`=0.
- SETTLE_CYCLES=0, NUM_PATTERNS=1: `done` at t+3, `pattern_count`=1.
- `abort` asserted in the second SETTLE: IDLE next cycle, `busy`=0, `done`=0, `pattern_count`=1. A new `start` then runs the full sequence from ACE1 again.
- `start` pulsed mid-run is ignored: `done` timing is unchanged. `start` in DONE clears `done` and begins a new run.
